// File: rtl/radix_4_pkg.sv
// ----------------------------------------------------------------------------
// radix_4_pkg
// Shared definitions for the radix-4 divider blocks.
//   - QUOT_NEG_2..QUOT_POS_2 : bit positions of the one-hot signed quotient
//                              digit produced by the sign coder
//   - QUOT_DIG_W             : width of the one-hot digit bus
//   - otfc_state_e           : state encoding of the on-the-fly converter
// ----------------------------------------------------------------------------
package radix_4_pkg;

    localparam int QUOT_NEG_2 = 0;
    localparam int QUOT_NEG_1 = 1;
    localparam int QUOT_ZERO  = 2;
    localparam int QUOT_POS_1 = 3;
    localparam int QUOT_POS_2 = 4;
    localparam int QUOT_DIG_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_CORR = 2'd2,
        ST_OUT  = 2'd3
    } otfc_state_e;

endpackage

// File: rtl/radix_4_otfc_step.sv
// ----------------------------------------------------------------------------
// radix_4_otfc_step
// One combinational on-the-fly conversion step. Appends one signed radix-4
// digit to the Q / QM pair (QM always equals Q-1). Both registers shift left
// by two and the top two bits fall off, so all values wrap modulo 2^QUOT_W.
// Ports:
//   q_i    : current Q
//   qm_i   : current QM
//   dig_i  : one-hot digit (bit indices from radix_4_pkg)
//   q_o    : next Q
//   qm_o   : next QM
//   inv_o  : digit was not one-hot; it has been applied as digit 0
// ----------------------------------------------------------------------------
module radix_4_otfc_step
    import radix_4_pkg::*;
#(
    parameter int QUOT_W = 64
) (
    input  logic [QUOT_W-1:0]     q_i,
    input  logic [QUOT_W-1:0]     qm_i,
    input  logic [QUOT_DIG_W-1:0] dig_i,
    output logic [QUOT_W-1:0]     q_o,
    output logic [QUOT_W-1:0]     qm_o,
    output logic                  inv_o
);

    logic [QUOT_W-1:0] q_sh;
    logic [QUOT_W-1:0] qm_sh;
    logic              one_hot;

    assign q_sh    = q_i << 2;
    assign qm_sh   = qm_i << 2;
    assign one_hot = $onehot(dig_i);
    assign inv_o   = ~one_hot;

    // Positive digits build from Q, negative digits borrow from QM; a zero
    // or malformed digit keeps each register on its own branch.
    always_comb begin
        q_o  = q_sh;
        qm_o = qm_sh | QUOT_W'(2'b11);
        if (one_hot) begin
            if (dig_i[QUOT_POS_2]) begin
                q_o  = q_sh | QUOT_W'(2'b10);
                qm_o = q_sh | QUOT_W'(2'b01);
            end else if (dig_i[QUOT_POS_1]) begin
                q_o  = q_sh | QUOT_W'(2'b01);
                qm_o = q_sh;
            end else if (dig_i[QUOT_NEG_1]) begin
                q_o  = qm_sh | QUOT_W'(2'b11);
                qm_o = qm_sh | QUOT_W'(2'b10);
            end else if (dig_i[QUOT_NEG_2]) begin
                q_o  = qm_sh | QUOT_W'(2'b10);
                qm_o = qm_sh | QUOT_W'(2'b01);
            end
        end
    end

endmodule

// File: rtl/radix_4_otfc.sv
// ----------------------------------------------------------------------------
// radix_4_otfc
// Radix-4 on-the-fly quotient converter. Accepts a start request with a
// digit count, consumes that many one-hot signed digits, waits for the
// final remainder sign and then presents the corrected binary quotient.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start_valid_i/_o  : start handshake (start_ready_o high when idle)
//   iter_num_i        : digit count, clamped to QUOT_W/2
//   quot_dig_valid_i  : digit beat valid
//   quot_dig_i        : one-hot digit (-2..+2)
//   rem_valid_i       : final remainder sign valid
//   rem_neg_i         : remainder negative, result is QM instead of Q
//   quot_valid_o      : result valid
//   quot_ready_i      : result consumer ready
//   quot_o            : corrected quotient, held until next result
//   err_o             : a malformed digit was seen in this conversion
// ----------------------------------------------------------------------------
module radix_4_otfc
    import radix_4_pkg::*;
#(
    parameter int QUOT_W = 64,
    parameter int ITER_W = $clog2(QUOT_W/2+1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic [ITER_W-1:0]     iter_num_i,
    input  logic                  quot_dig_valid_i,
    input  logic [QUOT_DIG_W-1:0] quot_dig_i,
    input  logic                  rem_valid_i,
    input  logic                  rem_neg_i,
    output logic                  quot_valid_o,
    input  logic                  quot_ready_i,
    output logic [QUOT_W-1:0]     quot_o,
    output logic                  err_o
);

    localparam logic [ITER_W-1:0] MAX_DIGITS = ITER_W'(QUOT_W/2);
    localparam logic [ITER_W-1:0] CNT_LAST   = ITER_W'(1);

    otfc_state_e       state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [QUOT_W-1:0] q_q, q_d;
    logic [QUOT_W-1:0] qm_q, qm_d;
    logic [QUOT_W-1:0] res_q, res_d;
    logic              err_q, err_d;

    logic [ITER_W-1:0] cnt_init;
    logic [QUOT_W-1:0] q_step;
    logic [QUOT_W-1:0] qm_step;
    logic              inv_step;
    logic              start_fire;
    logic              dig_fire;
    logic              rem_fire;

    assign cnt_init   = (iter_num_i > MAX_DIGITS) ? MAX_DIGITS : iter_num_i;
    assign start_fire = (state_q == ST_IDLE) && start_valid_i;
    assign dig_fire   = (state_q == ST_ITER) && quot_dig_valid_i;
    assign rem_fire   = (state_q == ST_CORR) && rem_valid_i;

    radix_4_otfc_step #(
        .QUOT_W (QUOT_W)
    ) u_step (
        .q_i   (q_q),
        .qm_i  (qm_q),
        .dig_i (quot_dig_i),
        .q_o   (q_step),
        .qm_o  (qm_step),
        .inv_o (inv_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A zero digit count skips straight to correction.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_valid_i) begin
                    state_d = (cnt_init != '0) ? ST_ITER : ST_CORR;
                end
            end
            ST_ITER: begin
                if (quot_dig_valid_i && (cnt_q == CNT_LAST)) begin
                    state_d = ST_CORR;
                end
            end
            ST_CORR: begin
                if (rem_valid_i) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (quot_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: handshake flags decode directly from the state.
    always_comb begin
        start_ready_o = (state_q == ST_IDLE);
        quot_valid_o  = (state_q == ST_OUT);
    end

    assign quot_o = res_q;
    assign err_o  = err_q;

    // Datapath next values. Everything holds unless its handshake fires.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        qm_d  = qm_q;
        res_d = res_q;
        err_d = err_q;
        if (start_fire) begin
            cnt_d = cnt_init;
            q_d   = '0;
            qm_d  = '1;
            err_d = 1'b0;
        end
        if (dig_fire) begin
            cnt_d = cnt_q - CNT_LAST;
            q_d   = q_step;
            qm_d  = qm_step;
            err_d = err_q | inv_step;
        end
        if (rem_fire) begin
            res_d = rem_neg_i ? qm_q : q_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            q_q   <= '0;
            qm_q  <= '1;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
            qm_q  <= qm_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_radix_4_otfc.sv
// ----------------------------------------------------------------------------
// tb_radix_4_otfc
// Self-checking bench for radix_4_otfc at QUOT_W=8. The reference model
// evaluates the digit string as a plain base-4 signed number.
// ----------------------------------------------------------------------------
module tb_radix_4_otfc;

    localparam int QUOT_W  = 8;
    localparam int ITER_W  = $clog2(QUOT_W/2+1);
    localparam int MAX_DIG = QUOT_W/2;

    localparam logic [4:0] D_M2 = 5'b00001;
    localparam logic [4:0] D_M1 = 5'b00010;
    localparam logic [4:0] D_Z  = 5'b00100;
    localparam logic [4:0] D_P1 = 5'b01000;
    localparam logic [4:0] D_P2 = 5'b10000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_valid_i = 1'b0;
    logic              start_ready_o;
    logic [ITER_W-1:0] iter_num_i = '0;
    logic              quot_dig_valid_i = 1'b0;
    logic [4:0]        quot_dig_i = '0;
    logic              rem_valid_i = 1'b0;
    logic              rem_neg_i = 1'b0;
    logic              quot_valid_o;
    logic              quot_ready_i = 1'b0;
    logic [QUOT_W-1:0] quot_o;
    logic              err_o;

    int         testsRun = 0;
    int         testsFailed = 0;
    logic [4:0] digBuf [8];

    radix_4_otfc #(
        .QUOT_W (QUOT_W),
        .ITER_W (ITER_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_valid_i    (start_valid_i),
        .start_ready_o    (start_ready_o),
        .iter_num_i       (iter_num_i),
        .quot_dig_valid_i (quot_dig_valid_i),
        .quot_dig_i       (quot_dig_i),
        .rem_valid_i      (rem_valid_i),
        .rem_neg_i        (rem_neg_i),
        .quot_valid_o     (quot_valid_o),
        .quot_ready_i     (quot_ready_i),
        .quot_o           (quot_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    // Signed value of a digit; anything not one-hot counts as zero.
    function automatic int digitValue(input logic [4:0] d);
        case (d)
            D_M2:    return -2;
            D_M1:    return -1;
            D_P1:    return 1;
            D_P2:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic digitOk(input logic [4:0] d);
        return (d == D_M2) || (d == D_M1) || (d == D_Z) || (d == D_P1) || (d == D_P2);
    endfunction

    // Quotient = sum of digits weighted by powers of 4, minus 1 when the
    // remainder is negative, reduced modulo 2^QUOT_W.
    function automatic logic [QUOT_W-1:0] modelQuot(input int n, input logic remNeg);
        longint acc;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            acc = acc * 4 + longint'(digitValue(digBuf[k]));
        end
        if (remNeg) begin
            acc = acc - 1;
        end
        return acc[QUOT_W-1:0];
    endfunction

    function automatic logic modelErr(input int n);
        logic e;
        e = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (!digitOk(digBuf[k])) e = 1'b1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setCase1();
        digBuf[0] = D_P1;
        digBuf[1] = D_P2;
        digBuf[2] = D_Z;
        digBuf[3] = D_M1;
    endtask

    // Runs one full conversion from start handshake to result handshake,
    // driving ignored inputs with noise in states where they must not matter.
    task automatic applyStimulus(input int iterNum, input int gapMin, input int gapMax,
                                 input logic remNeg, input int remDelay,
                                 input int holdCycles, input logic checkLat);
        int n;
        int cyc;
        int waitCnt;
        int gaps;
        logic [QUOT_W-1:0] expQ;
        logic expErr;

        n      = (iterNum > MAX_DIG) ? MAX_DIG : iterNum;
        expQ   = modelQuot(n, remNeg);
        expErr = modelErr(n);

        waitCnt = 0;
        while (!start_ready_o && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        if (!start_ready_o) begin
            checkOutput("startReadyTimeout", 64'd0, 64'd1);
            return;
        end

        start_valid_i = 1'b1;
        iter_num_i    = ITER_W'(iterNum);
        tick();
        start_valid_i = 1'b0;
        iter_num_i    = ITER_W'($urandom);
        cyc = 1;
        checkOutput("busyAfterStart", 64'(start_ready_o), 64'd0);

        for (int k = 0; k < n; k++) begin
            gaps = $urandom_range(gapMin, gapMax);
            repeat (gaps) begin
                quot_dig_valid_i = 1'b0;
                quot_dig_i       = 5'($urandom);
                rem_valid_i      = 1'($urandom);
                rem_neg_i        = 1'($urandom);
                tick();
                cyc++;
            end
            rem_valid_i      = 1'($urandom);
            quot_dig_valid_i = 1'b1;
            quot_dig_i       = digBuf[k];
            tick();
            cyc++;
        end
        quot_dig_valid_i = 1'b0;
        quot_dig_i       = '0;

        repeat (remDelay) begin
            rem_valid_i = 1'b0;
            rem_neg_i   = 1'($urandom);
            quot_dig_valid_i = 1'($urandom);
            tick();
            cyc++;
            checkOutput("noResultBeforeRem", 64'(quot_valid_o), 64'd0);
        end
        quot_dig_valid_i = 1'b0;
        rem_valid_i = 1'b1;
        rem_neg_i   = remNeg;

        waitCnt = 0;
        while (!quot_valid_o && waitCnt < 20) begin
            tick();
            cyc++;
            waitCnt++;
        end
        rem_valid_i = 1'b0;
        rem_neg_i   = 1'($urandom);
        if (!quot_valid_o) begin
            checkOutput("resultTimeout", 64'd0, 64'd1);
            return;
        end
        if (checkLat) begin
            checkOutput("latency", 64'(cyc), 64'(n + 2));
        end

        repeat (holdCycles) begin
            checkOutput("holdQuot", 64'(quot_o), 64'(expQ));
            checkOutput("holdErr", 64'(err_o), 64'(expErr));
            checkOutput("holdStartReady", 64'(start_ready_o), 64'd0);
            start_valid_i = 1'($urandom);
            iter_num_i    = ITER_W'($urandom);
            tick();
            checkOutput("holdValid", 64'(quot_valid_o), 64'd1);
        end
        start_valid_i = 1'b0;

        checkOutput("quot", 64'(quot_o), 64'(expQ));
        checkOutput("err", 64'(err_o), 64'(expErr));
        quot_ready_i = 1'b1;
        tick();
        quot_ready_i = 1'b0;
        checkOutput("idleAfterResult", 64'(start_ready_o), 64'd1);
        checkOutput("validDropped", 64'(quot_valid_o), 64'd0);
        checkOutput("quotKeptInIdle", 64'(quot_o), 64'(expQ));
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("rstStartReady", 64'(start_ready_o), 64'd1);
        checkOutput("rstQuotValid", 64'(quot_valid_o), 64'd0);
        checkOutput("rstQuot", 64'(quot_o), 64'd0);
        checkOutput("rstErr", 64'(err_o), 64'd0);

        // Directed cases.
        setCase1();
        applyStimulus(4, 0, 0, 1'b0, 0, 0, 1'b1);
        applyStimulus(4, 0, 0, 1'b1, 0, 0, 1'b1);
        for (int k = 0; k < 4; k++) digBuf[k] = D_M2;
        applyStimulus(4, 0, 0, 1'b0, 0, 0, 1'b1);
        setCase1();
        applyStimulus(4, 2, 2, 1'b0, 0, 0, 1'b0);
        applyStimulus(4, 0, 0, 1'b0, 0, 3, 1'b1);
        digBuf[1] = 5'b00110;
        applyStimulus(4, 0, 0, 1'b0, 0, 0, 1'b1);
        setCase1();
        applyStimulus(4, 0, 0, 1'b0, 0, 0, 1'b1);

        // Boundaries: zero digits, and a count above QUOT_W/2 that must clamp.
        applyStimulus(0, 0, 0, 1'b0, 0, 0, 1'b1);
        applyStimulus(0, 0, 0, 1'b1, 2, 1, 1'b0);
        for (int k = 0; k < 4; k++) digBuf[k] = D_P2;
        applyStimulus(7, 0, 0, 1'b1, 0, 0, 1'b1);

        // Reset in the middle of a conversion after the second digit.
        digBuf[0] = D_P1;
        digBuf[1] = 5'b11000;
        start_valid_i = 1'b1;
        iter_num_i    = ITER_W'(4);
        tick();
        start_valid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            quot_dig_valid_i = 1'b1;
            quot_dig_i       = digBuf[k];
            tick();
        end
        quot_dig_valid_i = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midRstStartReady", 64'(start_ready_o), 64'd1);
        checkOutput("midRstQuotValid", 64'(quot_valid_o), 64'd0);
        checkOutput("midRstQuot", 64'(quot_o), 64'd0);
        checkOutput("midRstErr", 64'(err_o), 64'd0);
        quot_dig_valid_i = 1'b1;
        quot_dig_i       = D_P2;
        rem_valid_i      = 1'b1;
        repeat (3) begin
            tick();
            checkOutput("midRstNoResult", 64'(quot_valid_o), 64'd0);
        end
        quot_dig_valid_i = 1'b0;
        rem_valid_i      = 1'b0;
        setCase1();
        applyStimulus(4, 0, 0, 1'b0, 0, 0, 1'b1);

        // Randomized conversions.
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    digBuf[k] = 5'($urandom);
                end else begin
                    digBuf[k] = 5'b00001 << $urandom_range(0, 4);
                end
            end
            applyStimulus($urandom_range(0, 7), 0, $urandom_range(0, 2), 1'($urandom),
                          $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
